// File: rtl/keycode_event_queue_if.sv
// Event read port of keycode_event_queue: head entry, non-empty flag, consumer pop.
// master = the queue (producer side), slave = the consumer.
interface keycode_event_queue_if;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;

    modport master (output evt_data, output evt_valid, input evt_ready);
    modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/keycode_event_queue.sv
// keycode_event_queue: turns the level keycode from the SoC PIO into a FIFO of
// press/release events ({repeat, press, keycode}) with a first-word-fall-through
// valid/ready read port, plus the currently held key as a level.
// Optional auto-repeat is compiled in when KEYCODE_REPEAT_EN is defined; otherwise
// evt_data[9] is always 0 and no repeat counter exists.
module keycode_event_queue #(
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [7:0]               keycode_in,
    keycode_event_queue_if.master    evt,
    output logic [7:0]               held_key,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keycode_event_queue: DEPTH must be a power of two, at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("keycode_event_queue: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

`ifdef KEYCODE_REPEAT_EN
    localparam int EW = 10;
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`else
    localparam int EW = 9;
`endif

    typedef enum logic {IDLE, PRESS_PEND} state_t;

    state_t        state;
    logic [7:0]    kc_q;
    logic          push;
    logic          push_press;
    logic [7:0]    push_key;
    logic [EW-1:0] push_entry;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

`ifdef KEYCODE_REPEAT_EN
    logic [RW-1:0] rpt_cnt;
    logic          push_rpt;
    logic          rpt_due;

    assign rpt_due    = (held_key != 8'h00) && (rpt_cnt == RPT_FIRE);
    assign push_entry = {push_rpt, push_press, push_key};
`else
    assign push_entry = {push_press, push_key};
`endif

    // Input capture: every decision is made on the registered keycode
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            kc_q <= 8'h00;
        end else begin
            kc_q <= keycode_in;
        end
    end

    // Event to push this cycle, decided from the current state and captured keycode
    always_comb begin
        push       = 1'b0;
        push_press = 1'b0;
        push_key   = 8'h00;
`ifdef KEYCODE_REPEAT_EN
        push_rpt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (kc_q != held_key) begin
                    push = 1'b1;
                    if (held_key != 8'h00) begin
                        // release of the old key always comes first
                        push_key = held_key;
                    end else begin
                        push_press = 1'b1;
                        push_key   = kc_q;
                    end
                end
`ifdef KEYCODE_REPEAT_EN
                else if (rpt_due) begin
                    push       = 1'b1;
                    push_press = 1'b1;
                    push_rpt   = 1'b1;
                    push_key   = held_key;
                end
`endif
            end
            PRESS_PEND: begin
                push       = 1'b1;
                push_press = 1'b1;
                push_key   = kc_q;
            end
            default: ;
        endcase
    end

    // Key-tracking FSM: held key, pending press after a key-to-key change, repeat timer
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            held_key <= 8'h00;
`ifdef KEYCODE_REPEAT_EN
            rpt_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (kc_q != held_key) begin
                        // A->B needs a second cycle for the press; A->0 and 0->B settle now
                        if (held_key != 8'h00 && kc_q != 8'h00) begin
                            state <= PRESS_PEND;
                        end else begin
                            held_key <= kc_q;
                        end
`ifdef KEYCODE_REPEAT_EN
                        rpt_cnt <= '0;
`endif
                    end
`ifdef KEYCODE_REPEAT_EN
                    else if (held_key != 8'h00) begin
                        rpt_cnt <= rpt_due ? RPT_RELOAD : rpt_cnt + 1'b1;
                    end
`endif
                end
                PRESS_PEND: begin
                    held_key <= kc_q;
                    state    <= IDLE;
`ifdef KEYCODE_REPEAT_EN
                    rpt_cnt  <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full   = (fifo_count == FULL_COUNT);
    assign pop    = evt.evt_valid && evt.evt_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign evt.evt_valid = (fifo_count != '0);
`ifdef KEYCODE_REPEAT_EN
    assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr] : 10'h000;
`else
    assign evt.evt_data  = evt.evt_valid ? {1'b0, mem[rd_ptr]} : 10'h000;
`endif

    // FIFO storage: written on accepted pushes only, contents need no reset
    always_ff @(posedge clk_clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Testbench for keycode_event_queue: a queue-based event model checked every cycle,
// plus directed scenarios with literal expectations. Define KEYCODE_REPEAT_EN for
// both files to exercise auto-repeat (REPEAT_DELAY=20, REPEAT_PERIOD=5).
`timescale 1ns/1ps
module tb_keycode_event_queue;

    localparam int DEPTH = 8;
    localparam int RD    = 20;
    localparam int RP    = 5;
`ifdef KEYCODE_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] keycode_in = 8'h00;
    logic       ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] held_key;
    logic [3:0] fifo_count;
    logic       overflow;

    keycode_event_queue_if evt_bus ();
    assign evt_bus.evt_ready = ready;

    keycode_event_queue #(
        .DEPTH         (DEPTH),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .keycode_in    (keycode_in),
        .evt           (evt_bus),
        .held_key      (held_key),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0]  mq[$];
    logic [7:0]  m_kcq = 8'h00;
    logic [7:0]  m_held = 8'h00;
    bit          m_pend = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_t = 0;
    int unsigned m_press_t = 0;

    task automatic model_step();
        logic [9:0] ev;
        bit have;
        bit do_pop;
        if (!rst_n) begin
            mq.delete();
            m_kcq = 8'h00; m_held = 8'h00; m_pend = 1'b0; m_ovf = 1'b0;
            m_t = 0; m_press_t = 0;
            return;
        end
        have = 1'b0;
        ev = 10'h000;
        do_pop = (mq.size() != 0) && ready;
        if (m_pend) begin
            ev = {2'b01, m_kcq}; have = 1'b1;
            m_held = m_kcq; m_pend = 1'b0; m_press_t = m_t;
        end else if (m_kcq != m_held) begin
            have = 1'b1;
            if (m_held != 8'h00) begin
                ev = {2'b00, m_held};
                if (m_kcq != 8'h00) m_pend = 1'b1;
                else m_held = 8'h00;
            end else begin
                ev = {2'b01, m_kcq}; m_held = m_kcq; m_press_t = m_t;
            end
        end else if (RPT_EN && m_held != 8'h00 && (m_t - m_press_t) >= RD
                     && ((m_t - m_press_t - RD) % RP) == 0) begin
            ev = {2'b11, m_held}; have = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1'b1;
        end else if (overflow_clr) begin
            m_ovf = 1'b0;
        end
        if (have && mq.size() < DEPTH && overflow_clr) m_ovf = 1'b0;
        m_kcq = keycode_in;
        m_t++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("evt_valid", evt_bus.evt_valid, mq.size() != 0);
        check("evt_data", evt_bus.evt_data, (mq.size() != 0) ? mq[0] : 10'h000);
        check("fifo_count", fifo_count, mq.size());
        check("held_key", held_key, m_held);
        check("overflow", overflow, m_ovf);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop1();
        ready = 1'b1; cyc(1); ready = 1'b0;
    endtask

    logic [7:0] seq1 [8] = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h12, 8'h13, 8'h00, 8'h14};
    logic [9:0] exp1 [8] = '{10'h007, 10'h110, 10'h010, 10'h111,
                             10'h011, 10'h112, 10'h012, 10'h113};
    logic [7:0] seq2 [8] = '{8'h15, 8'h00, 8'h16, 8'h00, 8'h17, 8'h00, 8'h18, 8'h00};

    initial begin
        #1 rst_n = 1'b0;
        cyc(3);
        check("reset valid", evt_bus.evt_valid, 0);
        check("reset data", evt_bus.evt_data, 0);
        check("reset count", fifo_count, 0);
        check("reset held", held_key, 0);
        check("reset overflow", overflow, 0);
        rst_n = 1'b1;
        cyc(100);
        check("idle valid", evt_bus.evt_valid, 0);

        // single press and pop
        keycode_in = 8'h1A;
        cyc(1);
        check("press latency valid", evt_bus.evt_valid, 0);
        cyc(1);
        check("press valid", evt_bus.evt_valid, 1);
        check("press data", evt_bus.evt_data, 10'h11A);
        check("press held", held_key, 8'h1A);
        pop1();
        check("press popped count", fifo_count, 0);

        // key-to-key change with consumer stalled
        keycode_in = 8'h07;
        cyc(4);
        check("a->b count", fifo_count, 2);
        check("a->b head release", evt_bus.evt_data, 10'h01A);
        pop1();
        check("a->b head press", evt_bus.evt_data, 10'h107);
        check("a->b held", held_key, 8'h07);
        pop1();
        check("a->b drained", fifo_count, 0);

        // overflow: 10 events into 8 entries
        foreach (seq1[i]) begin
            keycode_in = seq1[i];
            cyc(3);
        end
        check("ovf count", fifo_count, 8);
        check("ovf flag", overflow, 1);
        check("ovf held", held_key, 8'h14);
        keycode_in = 8'h00;
        cyc(3);
        check("ovf release dropped", fifo_count, 8);
        check("ovf held after drop", held_key, 8'h00);
        foreach (exp1[i]) begin
            check("ovf order", evt_bus.evt_data, exp1[i]);
            pop1();
        end
        overflow_clr = 1'b1; cyc(1); overflow_clr = 1'b0;
        check("ovf cleared", overflow, 0);

        // fill again, then push and pop on the same full cycle
        foreach (seq2[i]) begin
            keycode_in = seq2[i];
            cyc(3);
        end
        check("refill count", fifo_count, 8);
        keycode_in = 8'h19;
        cyc(1);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("push+pop full count", fifo_count, 8);
        check("push+pop no overflow", overflow, 0);
        check("push+pop head", evt_bus.evt_data, 10'h015);
        // drop coincides with clear: set wins
        keycode_in = 8'h00;
        cyc(1);
        overflow_clr = 1'b1; cyc(1); overflow_clr = 1'b0;
        check("set wins over clear", overflow, 1);
        overflow_clr = 1'b1; cyc(1); overflow_clr = 1'b0;
        check("clear after set", overflow, 0);
        ready = 1'b1; cyc(8); ready = 1'b0;
        check("refill drained", fifo_count, 0);

`ifdef KEYCODE_REPEAT_EN
        keycode_in = 8'h04;
        cyc(2);
        check("rpt press", evt_bus.evt_data, 10'h104);
        check("rpt count p", fifo_count, 1);
        cyc(19);
        check("rpt none before delay", fifo_count, 1);
        cyc(1);
        check("rpt first", fifo_count, 2);
        cyc(4);
        check("rpt none in period", fifo_count, 2);
        cyc(1);
        check("rpt second", fifo_count, 3);
        cyc(5);
        check("rpt third", fifo_count, 4);
        pop1();
        check("rpt data", evt_bus.evt_data, 10'h304);
        keycode_in = 8'h00;
        cyc(2);
        check("rpt release count", fifo_count, 4);
        cyc(20);
        check("rpt stopped", fifo_count, 4);
        ready = 1'b1; cyc(3); ready = 1'b0;
        check("rpt release data", evt_bus.evt_data, 10'h004);
        pop1();
        check("rpt drained", fifo_count, 0);
`else
        keycode_in = 8'h04;
        cyc(2);
        check("hold press", evt_bus.evt_data, 10'h104);
        cyc(40);
        check("hold no repeat", fifo_count, 1);
        keycode_in = 8'h00;
        cyc(2);
        check("hold release", fifo_count, 2);
        pop1();
        check("hold release data", evt_bus.evt_data, 10'h004);
        pop1();
        check("hold drained", fifo_count, 0);
`endif

        // asynchronous reset with entries queued
        keycode_in = 8'h20; cyc(3);
        keycode_in = 8'h00; cyc(3);
        keycode_in = 8'h21; cyc(3);
        check("pre-reset count", fifo_count, 3);
        check("pre-reset head", evt_bus.evt_data, 10'h120);
        keycode_in = 8'h1A;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", evt_bus.evt_valid, 0);
        check("async rst data", evt_bus.evt_data, 0);
        check("async rst count", fifo_count, 0);
        check("async rst held", held_key, 0);
        check("async rst overflow", overflow, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("post-reset latency", evt_bus.evt_valid, 0);
        cyc(1);
        check("post-reset press", evt_bus.evt_data, 10'h11A);
        check("post-reset held", held_key, 8'h1A);
        check("post-reset count", fifo_count, 1);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
